// File: rtl/nes_loader.sv
// Program loader for a NES core: host opcodes stream bytes into program memory and start/halt the CPU.
// Optional feature macro: NES_LOADER_READBACK_EN adds memory readback through read register 2.
module nes_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CMD_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [CMD_W+DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    read,
    output logic [ADDR_W:0]         readdata,
    output logic                    waitrequest,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    cpu_reset,
    output logic                    cpu_ready,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CMD_W-1:0] OP_RESET_CPU   = CMD_W'(0);
    localparam logic [CMD_W-1:0] OP_START_CPU   = CMD_W'(1);
    localparam logic [CMD_W-1:0] OP_START_WRITE = CMD_W'(2);
    localparam logic [CMD_W-1:0] OP_WRITE       = CMD_W'(3);
    localparam logic [CMD_W-1:0] OP_STOP_WRITE  = CMD_W'(4);
    localparam logic [CMD_W-1:0] OP_HALT_CPU    = CMD_W'(5);
    localparam logic [CMD_W-1:0] OP_SET_RB      = CMD_W'(6);
    localparam logic [ADDR_W:0]  LEN_MAX        = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W:0]     prog_len_q, prog_len_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic [ADDR_W:0]     readdata_q, readdata_d;

    logic                wr_en, rd_en, rb_busy;
    logic [CMD_W-1:0]    op;
    logic [DATA_W-1:0]   payload;

    // Handshake: a write command is accepted on any cycle with chipselect && write (never stalled).
    // A read is chipselect && read && !write; data appears on readdata the following cycle unless
    // waitrequest rises, in which case the data follows one cycle after waitrequest drops.
    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read & ~write & ~rb_busy;
    assign op      = writedata[CMD_W+DATA_W-1 -: CMD_W];
    assign payload = writedata[DATA_W-1:0];

`ifdef NES_LOADER_READBACK_EN
    logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
    logic              waitrequest_q, waitrequest_d;
    logic              rb_data_q, rb_data_d;

    // The stall cycle presents rb_addr to memory; the following cycle forwards the memory output.
    assign rb_busy     = waitrequest_q | rb_data_q;
    assign waitrequest = waitrequest_q;
    assign readdata    = rb_data_q ? (ADDR_W+1)'(mem_rdata) : readdata_q;
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
    assign rb_busy      = 1'b0;
    assign waitrequest  = 1'b0;
    assign readdata     = readdata_q;
`endif

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_reset = cpu_reset_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            prog_len_q    <= '0;
            wrap_q        <= 1'b0;
            err_q         <= 1'b0;
            cpu_reset_q   <= 1'b1;
            cpu_ready_q   <= 1'b0;
            readdata_q    <= '0;
`ifdef NES_LOADER_READBACK_EN
            rb_addr_q     <= '0;
            waitrequest_q <= 1'b0;
            rb_data_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            prog_len_q    <= prog_len_d;
            wrap_q        <= wrap_d;
            err_q         <= err_d;
            cpu_reset_q   <= cpu_reset_d;
            cpu_ready_q   <= cpu_ready_d;
            readdata_q    <= readdata_d;
`ifdef NES_LOADER_READBACK_EN
            rb_addr_q     <= rb_addr_d;
            waitrequest_q <= waitrequest_d;
            rb_data_q     <= rb_data_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        prog_len_d  = prog_len_q;
        wrap_d      = wrap_q;
        err_d       = err_q;
        cpu_reset_d = cpu_reset_q;
        cpu_ready_d = cpu_ready_q;
        readdata_d  = readdata_q;
`ifdef NES_LOADER_READBACK_EN
        rb_addr_d     = rb_addr_q;
        waitrequest_d = 1'b0;
        rb_data_d     = waitrequest_q;
        if (rb_data_q) begin
            readdata_d = (ADDR_W+1)'(mem_rdata);
            rb_addr_d  = rb_addr_q + 1'b1;
        end
`endif
        if (wr_en) begin
            case (op)
                OP_RESET_CPU: begin
                    state_d     = ST_IDLE;
                    cpu_reset_d = 1'b1;
                    cpu_ready_d = 1'b0;
                    prog_len_d  = '0;
                    wrap_d      = 1'b0;
                    err_d       = 1'b0;
                end
                OP_START_CPU: begin
                    if (state_q == ST_IDLE) begin
                        state_d     = ST_RUN;
                        cpu_reset_d = 1'b0;
                        cpu_ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_START_WRITE: begin
                    if (state_q != ST_RUN) begin
                        state_d     = ST_LOAD;
                        mem_addr_d  = address;
                        mem_wdata_d = payload;
                        mem_we_d    = 1'b1;
                        prog_len_d  = (ADDR_W+1)'(1);
                        wrap_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_WRITE: begin
                    if (state_q == ST_LOAD) begin
                        mem_addr_d  = mem_addr_q + 1'b1;
                        mem_wdata_d = payload;
                        mem_we_d    = 1'b1;
                        prog_len_d  = (prog_len_q == LEN_MAX) ? prog_len_q : prog_len_q + 1'b1;
                        if (&mem_addr_q) wrap_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STOP_WRITE: begin
                    if (state_q == ST_LOAD) state_d = ST_IDLE;
                end
                OP_HALT_CPU: begin
                    if (state_q == ST_RUN) begin
                        state_d     = ST_IDLE;
                        cpu_ready_d = 1'b0;
                    end
                end
`ifdef NES_LOADER_READBACK_EN
                OP_SET_RB: begin
                    if (state_q == ST_IDLE) rb_addr_d = address;
                end
`endif
                default: ;
            endcase
        end else if (rd_en) begin
            if (address == ADDR_W'(0)) begin
                readdata_d = (ADDR_W+1)'({state_q, err_q, wrap_q});
            end else if (address == ADDR_W'(1)) begin
                readdata_d = prog_len_q;
            end else if (address == ADDR_W'(2)) begin
`ifdef NES_LOADER_READBACK_EN
                if (state_q == ST_IDLE) begin
                    waitrequest_d = 1'b1;
                    mem_addr_d    = rb_addr_q;
                end else begin
                    readdata_d = '0;
                    err_d      = 1'b1;
                end
`else
                readdata_d = '0;
`endif
            end else begin
                readdata_d = '0;
            end
        end
    end

endmodule
